// File: rtl/regfile_wr_ctrl_pkg.sv
// Shared types and constants for the register-file write-side controller.
// Contents: bus widths, zero word, reset/write-enable polarities and the
// auxiliary write queue entry {live, addr, data}.
package regfile_wr_ctrl_pkg;

   localparam int unsigned RegBus     = 32;
   localparam int unsigned RegAddrBus = 5;

   localparam logic [RegBus-1:0] ZeroWord    = '0;
   localparam logic              RstEnable   = 1'b1;
   localparam logic              WriteEnable = 1'b1;

   // live = 0 marks an entry killed by a younger pipe write (or already drained).
   typedef struct packed {
      logic                  live;
      logic [RegAddrBus-1:0] addr;
      logic [RegBus-1:0]     data;
   } wrq_entry_t;

endpackage

// File: rtl/regfile_wr_ctrl_if.sv
// Bundle of all non-clock/reset signals of regfile_wr_ctrl.
//   pipe_*          : MEM/WB write request (never stalls)
//   aux_*           : late-result valid/ready write request
//   we/waddr/wdata  : merged regfile write port
//   raddr*/pend*    : decode hazard query
//   fwd_*           : decode forwarding (meaningful only with REGFILE_WR_FWD_EN)
//   count           : queue occupancy, killed entries included
// Modports: master = environment/pipeline side, slave = controller side.
interface regfile_wr_ctrl_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              pipe_we;
   logic [ADDR_W-1:0] pipe_waddr;
   logic [DATA_W-1:0] pipe_wdata;
   logic              aux_valid;
   logic              aux_ready;
   logic [ADDR_W-1:0] aux_waddr;
   logic [DATA_W-1:0] aux_wdata;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic              pend1;
   logic              pend2;
   logic              fwd_hit1;
   logic [DATA_W-1:0] fwd_data1;
   logic              fwd_hit2;
   logic [DATA_W-1:0] fwd_data2;
   logic [CNT_W-1:0]  count;

   modport master (
      output pipe_we, pipe_waddr, pipe_wdata, aux_valid, aux_waddr, aux_wdata, raddr1, raddr2,
      input  aux_ready, we, waddr, wdata, pend1, pend2, fwd_hit1, fwd_data1, fwd_hit2,
             fwd_data2, count
   );

   modport slave (
      input  pipe_we, pipe_waddr, pipe_wdata, aux_valid, aux_waddr, aux_wdata, raddr1, raddr2,
      output aux_ready, we, waddr, wdata, pend1, pend2, fwd_hit1, fwd_data1, fwd_hit2,
             fwd_data2, count
   );

endinterface

// File: rtl/wrq_match.sv
// Address comparator over the auxiliary write queue.
//   entries : queue storage
//   head    : oldest slot; scan runs head -> tail so the last match is the youngest
//   raddr   : read address being looked up (r0 never matches)
//   hit     : some live entry targets raddr
//   idx     : slot of the youngest live match (head when no hit)
module wrq_match
   import regfile_wr_ctrl_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  wrq_entry_t [DEPTH-1:0] entries,
   input  logic [PTR_W-1:0]       head,
   input  logic [RegAddrBus-1:0]  raddr,
   output logic                   hit,
   output logic [PTR_W-1:0]       idx
);

   logic [PTR_W-1:0] slot;

   always_comb begin
      hit  = 1'b0;
      idx  = head;
      slot = head;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         // DEPTH is a power of two, so the sum wraps naturally.
         slot = head + PTR_W'(k);
         if (entries[slot].live && (entries[slot].addr == raddr) && (raddr != '0)) begin
            hit = 1'b1;
            idx = slot;
         end
      end
   end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Write-side controller for the single regfile write port.
// The MEM/WB pipe write always wins; auxiliary results are queued and drained
// into idle slots. A pipe write kills any older queued write to the same
// register. Pending status per decode read port is exported for stalling.
// Ports: clk, rst (synchronous, active-high), bus (regfile_wr_ctrl_if.slave).
// DATA_W/ADDR_W must equal the package RegBus/RegAddrBus widths.
// Optional: define REGFILE_WR_FWD_EN to drive fwd_hit*/fwd_data* from the
// youngest live queued write; otherwise they are tied to zero.
module regfile_wr_ctrl
   import regfile_wr_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = RegBus,
   parameter int unsigned ADDR_W = RegAddrBus,
   parameter int unsigned DEPTH  = 4
) (
   input logic             clk,
   input logic             rst,
   regfile_wr_ctrl_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   wrq_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;

   logic             pipe_wr, head_live, pop, push;
   logic             hit1, hit2;
   logic [PTR_W-1:0] idx1, idx2;

   // A pipe write to r0 is treated as an idle slot.
   assign pipe_wr   = bus.pipe_we && (bus.pipe_waddr != '0);
   // Drained/killed slots have live cleared, so live implies occupancy.
   assign head_live = mem_q[head_q].live;
   // A dead head is discarded even while the pipe owns the port.
   assign pop       = (count_q != '0) && (!head_live || !pipe_wr);
   // r0 targets and writes superseded by a same-cycle pipe write are accepted but dropped.
   assign push      = bus.aux_valid && bus.aux_ready && (bus.aux_waddr != '0) &&
                      !(pipe_wr && (bus.aux_waddr == bus.pipe_waddr));

   assign bus.aux_ready = (count_q != CNT_W'(DEPTH));
   assign bus.count     = count_q;

   always_comb begin
      mem_d     = mem_q;
      head_d    = head_q;
      tail_d    = tail_q;
      bus.we    = 1'b0;
      bus.waddr = '0;
      bus.wdata = ZeroWord;

      // Write port is held off during reset so no queued write escapes.
      if (rst != RstEnable) begin
         if (pipe_wr) begin
            bus.we    = WriteEnable;
            bus.waddr = bus.pipe_waddr;
            bus.wdata = bus.pipe_wdata;
         end else if (head_live) begin
            bus.we    = WriteEnable;
            bus.waddr = mem_q[head_q].addr;
            bus.wdata = mem_q[head_q].data;
         end
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (pipe_wr && (mem_q[i].addr == bus.pipe_waddr)) begin
            mem_d[i].live = 1'b0;
         end
      end

      if (pop) begin
         mem_d[head_q].live = 1'b0;
         head_d             = head_q + PTR_W'(1);
      end

      if (push) begin
         mem_d[tail_q] = '{live: 1'b1, addr: bus.aux_waddr, data: bus.aux_wdata};
         tail_d        = tail_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         mem_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   wrq_match #(.DEPTH(DEPTH)) u_match1 (
      .entries (mem_q),
      .head    (head_q),
      .raddr   (bus.raddr1),
      .hit     (hit1),
      .idx     (idx1)
   );

   wrq_match #(.DEPTH(DEPTH)) u_match2 (
      .entries (mem_q),
      .head    (head_q),
      .raddr   (bus.raddr2),
      .hit     (hit2),
      .idx     (idx2)
   );

   assign bus.pend1 = hit1;
   assign bus.pend2 = hit2;

`ifdef REGFILE_WR_FWD_EN
   assign bus.fwd_hit1  = hit1;
   assign bus.fwd_hit2  = hit2;
   assign bus.fwd_data1 = hit1 ? mem_q[idx1].data : ZeroWord;
   assign bus.fwd_data2 = hit2 ? mem_q[idx2].data : ZeroWord;
`else
   // Youngest-match index has no consumer without forwarding.
   logic unused_idx;
   assign unused_idx    = ^{idx1, idx2};
   assign bus.fwd_hit1  = 1'b0;
   assign bus.fwd_hit2  = 1'b0;
   assign bus.fwd_data1 = ZeroWord;
   assign bus.fwd_data2 = ZeroWord;
`endif

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Self-checking bench for regfile_wr_ctrl: directed vector table, a full-queue
// sequence, and randomized traffic against a queue-based reference model.
module tb_regfile_wr_ctrl;

   localparam int unsigned DEPTH = 4;
`ifdef REGFILE_WR_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_wr_ctrl_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) bus ();

   regfile_wr_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        rst;
      logic        pwe;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic [4:0]  r1;
      logic [4:0]  r2;
   } in_t;

   typedef struct {
      in_t         i;
      bit          chk;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        rdy;
      logic [2:0]  cnt;
      logic        p1;
      logic        p2;
      logic [31:0] fd1;
   } row_t;

   typedef struct {
      bit          live;
      logic [4:0]  addr;
      logic [31:0] data;
   } ment_t;

   ment_t mq[$];
   row_t  tbl[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic drive(input in_t v);
      rst            = v.rst;
      bus.pipe_we    = v.pwe;
      bus.pipe_waddr = v.pa;
      bus.pipe_wdata = v.pd;
      bus.aux_valid  = v.av;
      bus.aux_waddr  = v.aa;
      bus.aux_wdata  = v.ad;
      bus.raddr1     = v.r1;
      bus.raddr2     = v.r2;
   endtask

   function automatic in_t mk(input logic r, pwe, input logic [4:0] pa, input logic [31:0] pd,
                              input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic [4:0] r1, r2);
      in_t v;
      v = '{rst: r, pwe: pwe, pa: pa, pd: pd, av: av, aa: aa, ad: ad, r1: r1, r2: r2};
      return v;
   endfunction

   task automatic add(input in_t v, input bit chk, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic rdy, input logic [2:0] cnt,
                      input logic p1, p2, input logic [31:0] fd1);
      row_t r;
      r.i = v; r.chk = chk; r.we = we; r.wa = wa; r.wd = wd; r.rdy = rdy; r.cnt = cnt;
      r.p1 = p1; r.p2 = p2; r.fd1 = fd1;
      tbl.push_back(r);
   endtask

   // Reference model: youngest live match in the queue for a read address.
   function automatic bit m_lookup(input logic [4:0] ra, output logic [31:0] d);
      bit h = 1'b0;
      d = 32'h0;
      if (ra == 5'd0) return 1'b0;
      foreach (mq[k]) if (mq[k].live && mq[k].addr == ra) begin h = 1'b1; d = mq[k].data; end
      return h;
   endfunction

   task automatic model_check(input in_t v, input string tag);
      bit          pw, h1, h2;
      logic [31:0] d1, d2;
      logic        e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      pw   = v.pwe && v.pa != 5'd0;
      e_we = 1'b0; e_wa = 5'd0; e_wd = 32'h0;
      if (!v.rst) begin
         if (pw) begin e_we = 1'b1; e_wa = v.pa; e_wd = v.pd; end
         else if (mq.size() > 0 && mq[0].live) begin
            e_we = 1'b1; e_wa = mq[0].addr; e_wd = mq[0].data;
         end
      end
      h1 = m_lookup(v.r1, d1);
      h2 = m_lookup(v.r2, d2);
      check({tag, "_we"},    32'(bus.we),        32'(e_we));
      check({tag, "_waddr"}, 32'(bus.waddr),     32'(e_wa));
      check({tag, "_wdata"}, bus.wdata,          e_wd);
      check({tag, "_ready"}, 32'(bus.aux_ready), 32'(mq.size() != DEPTH));
      check({tag, "_count"}, 32'(bus.count),     mq.size());
      check({tag, "_pend1"}, 32'(bus.pend1),     32'(h1));
      check({tag, "_pend2"}, 32'(bus.pend2),     32'(h2));
      check({tag, "_fhit1"}, 32'(bus.fwd_hit1),  32'(FWD && h1));
      check({tag, "_fhit2"}, 32'(bus.fwd_hit2),  32'(FWD && h2));
      check({tag, "_fdat1"}, bus.fwd_data1,      FWD ? d1 : 32'h0);
      check({tag, "_fdat2"}, bus.fwd_data2,      FWD ? d2 : 32'h0);
   endtask

   // Advance the model across one clock edge with inputs v.
   function automatic void model_edge(input in_t v);
      bit    pw, do_pop, rdy;
      ment_t e;
      if (v.rst) begin mq.delete(); return; end
      pw     = v.pwe && v.pa != 5'd0;
      rdy    = mq.size() != DEPTH;
      do_pop = mq.size() > 0 && (!mq[0].live || !pw);
      foreach (mq[k]) if (pw && mq[k].addr == v.pa) mq[k].live = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (v.av && rdy && v.aa != 5'd0 && !(pw && v.aa == v.pa)) begin
         e.live = 1'b1; e.addr = v.aa; e.data = v.ad;
         mq.push_back(e);
      end
   endfunction

   task automatic model_step(input in_t v, input string tag);
      drive(v);
      @(negedge clk);
      model_check(v, tag);
      model_edge(v);
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_t v;
      int  ai;
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

      //   rst pwe pa  pd        av aa  ad        r1 r2   chk we wa wd        rdy cnt p1 p2 fd1
      add(mk(1, 0, 0, 0,        0, 0, 0,        0, 0), 0, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0,        0, 0, 0,        5, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0,        1, 5, 'h1234,   5, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0,        0, 0, 0,        5, 0), 1, 1, 5, 'h1234,   1, 1, 1, 0, 'h1234);
      add(mk(0, 0, 0, 0,        0, 0, 0,        5, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0,        1, 7, 'hAAAA,   7, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 1, 7, 'hBBBB,   0, 0, 0,        7, 0), 1, 1, 7, 'hBBBB,   1, 1, 1, 0, 'hAAAA);
      add(mk(0, 0, 0, 0,        0, 0, 0,        7, 0), 1, 0, 0, 0,        1, 1, 0, 0, 0);
      add(mk(0, 0, 0, 0,        0, 0, 0,        7, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0,        1, 3, 'h11,     3, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 1, 2, 'h55,     1, 3, 'h22,     3, 0), 1, 1, 2, 'h55,     1, 1, 1, 0, 'h11);
      add(mk(0, 1, 2, 'h66,     0, 0, 0,        3, 0), 1, 1, 2, 'h66,     1, 2, 1, 0, 'h22);
      add(mk(0, 0, 0, 0,        0, 0, 0,        3, 3), 1, 1, 3, 'h11,     1, 2, 1, 1, 'h22);
      add(mk(0, 0, 0, 0,        0, 0, 0,        3, 0), 1, 1, 3, 'h22,     1, 1, 1, 0, 'h22);
      add(mk(0, 0, 0, 0,        0, 0, 0,        3, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0,        1, 0, 'hDEAD,   0, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0,        0, 0, 0,        0, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0,        1, 4, 'h44,     4, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 1, 0, 'h99,     0, 0, 0,        4, 0), 1, 1, 4, 'h44,     1, 1, 1, 0, 'h44);
      add(mk(0, 0, 0, 0,        0, 0, 0,        4, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 1, 1, 'h1,      1, 8, 'h80,     0, 0), 1, 1, 1, 'h1,      1, 0, 0, 0, 0);
      add(mk(0, 1, 2, 'h2,      1, 9, 'h90,     0, 0), 1, 1, 2, 'h2,      1, 1, 0, 0, 0);
      add(mk(0, 1, 3, 'h3,      1, 10, 'hA0,    8, 0), 1, 1, 3, 'h3,      1, 2, 1, 0, 'h80);
      add(mk(1, 0, 0, 0,        0, 0, 0,        8, 0), 1, 0, 0, 0,        1, 3, 1, 0, 'h80);
      add(mk(0, 0, 0, 0,        0, 0, 0,        8, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0,        0, 0, 0,        0, 0), 1, 0, 0, 0,        1, 0, 0, 0, 0);
      add(mk(0, 1, 6, 'h6,      1, 6, 'h77,     0, 6), 1, 1, 6, 'h6,      1, 0, 0, 0, 0);
      add(mk(0, 0, 0, 0,        0, 0, 0,        0, 6), 1, 0, 0, 0,        1, 0, 0, 0, 0);

      @(posedge clk);
      #1;
      foreach (tbl[n]) begin
         drive(tbl[n].i);
         @(negedge clk);
         if (tbl[n].chk) begin
            check($sformatf("row%0d_we", n),    32'(bus.we),        32'(tbl[n].we));
            check($sformatf("row%0d_waddr", n), 32'(bus.waddr),     32'(tbl[n].wa));
            check($sformatf("row%0d_wdata", n), bus.wdata,          tbl[n].wd);
            check($sformatf("row%0d_ready", n), 32'(bus.aux_ready), 32'(tbl[n].rdy));
            check($sformatf("row%0d_count", n), 32'(bus.count),     32'(tbl[n].cnt));
            check($sformatf("row%0d_pend1", n), 32'(bus.pend1),     32'(tbl[n].p1));
            check($sformatf("row%0d_pend2", n), 32'(bus.pend2),     32'(tbl[n].p2));
            check($sformatf("row%0d_fhit1", n), 32'(bus.fwd_hit1),  32'(FWD && tbl[n].p1));
            check($sformatf("row%0d_fdat1", n), bus.fwd_data1,      FWD ? tbl[n].fd1 : 32'h0);
         end
         model_edge(tbl[n].i);
         @(posedge clk);
         #1;
      end

      // Pipe busy r1..r6 while aux offers r8..r12; queue fills, then drains in order.
      ai = 0;
      for (int c = 0; c < 14; c++) begin
         v = mk(0, c < 6, 5'(c + 1), 32'h100 + c, ai < 5, 5'(8 + ai), 32'h800 + ai, 5'd8, 5'd12);
         drive(v);
         @(negedge clk);
         if (c == 4) begin
            check("full_count", 32'(bus.count), 32'd4);
            check("full_ready", 32'(bus.aux_ready), 32'd0);
         end
         if (c == 6) check("full_pop_ready", 32'(bus.aux_ready), 32'd0);
         model_check(v, $sformatf("full%0d", c));
         if (v.av && mq.size() != DEPTH) ai++;
         model_edge(v);
         @(posedge clk);
         #1;
      end

      // Randomized traffic over a small address range to provoke hits and kills.
      for (int c = 0; c < 800; c++) begin
         v = mk($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)));
         model_step(v, $sformatf("rnd%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
